// File: rtl/qr_pkg.sv
// Shared constants and types for the QR request scheduler.
package qr_pkg;

  localparam int SIZE        = 3072;
  localparam int RADIX       = 54;
  localparam int OPW         = SIZE + RADIX + 1;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/qr_sched_if.sv
// Requester-side handshake bundle of qr_sched: request channel plus response channel.
interface qr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]              req_valid;
  logic [NREQ*qr_pkg::OPW-1:0]  req_a;
  logic [NREQ-1:0]              req_ready;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [IDW-1:0]               rsp_id;
  logic [qr_pkg::SIZE-1:0]      rsp_data;
  logic                         rsp_err;

  modport slave (
    input  req_valid, req_a, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_a, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; the pointer holds the first index to search,
// i.e. one past the last accepted grant, so reset starts the search at 0.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         upd,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    int  idx;
    logic found;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = W'(idx);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd) ptr_d = (gnt_idx == W'(N-1)) ? '0 : gnt_idx + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/qr_sched.sv
// Serialises NREQ requesters onto a single QR reduction unit, one operation in
// flight, with shared modulus configuration and a completion watchdog.
module qr_sched
  import qr_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [SIZE-1:0]   cfg_m,
  input  logic [SIZE+1:0]   cfg_m_n,
  input  logic [RADIX+1:0]  cfg_m_prime,
  output logic              cfg_busy,
  qr_sched_if.slave         rq,
  output logic [OPW-1:0]    qr_a,
  output logic [SIZE-1:0]   qr_m,
  output logic [SIZE+1:0]   qr_m_n,
  output logic [RADIX+1:0]  qr_m_prime,
  output logic              qr_en,
  input  logic              qr_en_out,
  input  logic [SIZE-1:0]   qr_new_a
);

  localparam int WDW = $clog2(TIMEOUT) + 1;

  state_e            state_q, state_d;
  logic [OPW-1:0]    qr_a_q, qr_a_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic [SIZE-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [SIZE-1:0]   m_q, m_d;
  logic [SIZE+1:0]   m_n_q, m_n_d;
  logic [RADIX+1:0]  m_prime_q, m_prime_d;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              idle;
  logic              hs;

  assign idle = (state_q == IDLE);
  assign hs   = |(rq.req_valid & gnt);

  rr_arbiter #(
    .N (NREQ),
    .W (IDW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (idle),
    .req     (rq.req_valid),
    .upd     (hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      qr_a_q     <= '0;
      id_q       <= '0;
      wdog_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      m_q        <= '0;
      m_n_q      <= '0;
      m_prime_q  <= '0;
    end else begin
      state_q    <= state_d;
      qr_a_q     <= qr_a_d;
      id_q       <= id_d;
      wdog_q     <= wdog_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      m_q        <= m_d;
      m_n_q      <= m_n_d;
      m_prime_q  <= m_prime_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    qr_a_d     = qr_a_q;
    id_d       = id_q;
    wdog_d     = wdog_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    m_d        = m_q;
    m_n_d      = m_n_q;
    m_prime_d  = m_prime_q;

    // A write in the same cycle as a handshake lands before qr_en, so it applies to that operation.
    if (cfg_we && idle) begin
      m_d       = cfg_m;
      m_n_d     = cfg_m_n;
      m_prime_d = cfg_m_prime;
    end

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          qr_a_d  = rq.req_a[int'(gnt_idx)*OPW +: OPW];
          id_d    = gnt_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + WDW'(1);
        if (qr_en_out) begin
          rsp_data_d = qr_new_a;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wdog_d == WDW'(TIMEOUT-1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rq.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    qr_en        = (state_q == ISSUE);
    cfg_busy     = !idle;
    rq.req_ready = gnt;
    rq.rsp_valid = (state_q == RESP);
    rq.rsp_id    = id_q;
    rq.rsp_data  = rsp_data_q;
    rq.rsp_err   = rsp_err_q;
    qr_a         = qr_a_q;
    qr_m         = m_q;
    qr_m_n       = m_n_q;
    qr_m_prime   = m_prime_q;
  end

endmodule

// File: tb/tb_qr_sched.sv
// Scoreboard bench for qr_sched with a fixed-latency QR model returning a mod m.
module tb_qr_sched;
  import qr_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TO   = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [SIZE-1:0]   cfg_m = '0;
  logic [SIZE+1:0]   cfg_m_n = '0;
  logic [RADIX+1:0]  cfg_m_prime = '0;
  logic              cfg_busy;
  logic [OPW-1:0]    qr_a;
  logic [SIZE-1:0]   qr_m;
  logic [SIZE+1:0]   qr_m_n;
  logic [RADIX+1:0]  qr_m_prime;
  logic              qr_en;
  logic              qr_en_out = 1'b0;
  logic [SIZE-1:0]   qr_new_a = '1;

  qr_sched_if #(.NREQ(NREQ), .IDW(IDW)) rq ();

  qr_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_m       (cfg_m),
    .cfg_m_n     (cfg_m_n),
    .cfg_m_prime (cfg_m_prime),
    .cfg_busy    (cfg_busy),
    .rq          (rq),
    .qr_a        (qr_a),
    .qr_m        (qr_m),
    .qr_m_n      (qr_m_n),
    .qr_m_prime  (qr_m_prime),
    .qr_en       (qr_en),
    .qr_en_out   (qr_en_out),
    .qr_new_a    (qr_new_a)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
    logic [OPW-1:0] a;
    logic [OPW-1:0] e;
    a = act;
    e = exp;
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits shown)", name, a[63:0], e[63:0]);
    end
  endtask

  typedef struct {
    logic [IDW-1:0]  id;
    logic [SIZE-1:0] data;
    logic            err;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input int id, input logic [SIZE-1:0] data, input logic err);
    exp_t e;
    e.id   = IDW'(id);
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // QR model: result appears lat cycles after the qr_en cycle; hang suppresses it.
  int             lat  = 12;
  bit             hang = 1'b0;
  bit             busy = 1'b0;
  int             cnt  = 0;
  logic [OPW-1:0] a_l;
  logic [SIZE-1:0] m_l;
  logic [OPW-1:0] r_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy      = 1'b0;
      qr_en_out = 1'b0;
      qr_new_a  = '1;
    end else if (qr_en) begin
      busy      = 1'b1;
      cnt       = lat;
      a_l       = qr_a;
      m_l       = qr_m;
      qr_en_out = 1'b0;
      qr_new_a  = '1;
    end else begin
      qr_en_out = 1'b0;
      qr_new_a  = '1;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          if (!hang) begin
            r_l       = (m_l == '0) ? a_l : a_l % {{(OPW-SIZE){1'b0}}, m_l};
            qr_en_out = 1'b1;
            qr_new_a  = r_l[SIZE-1:0];
          end
        end
      end
    end
  end

  // Monitor: compares every accepted response against the scoreboard and polices qr_en pulses.
  int   en_cnt  = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && rq.rsp_valid && rq.rsp_ready) begin
      check("rsp_expected", OPW'(exp_q.size() != 0), OPW'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_id",   rq.rsp_id,   e.id);
        check("rsp_data", rq.rsp_data, e.data);
        check("rsp_err",  rq.rsp_err,  e.err);
      end
    end
    if (qr_en) begin
      check("qr_en_single_cycle", prev_en, 1'b0);
      en_cnt++;
    end
    prev_en = qr_en;
  end

  task automatic set_req(input int i, input logic [OPW-1:0] a);
    rq.req_a[i*OPW +: OPW] = a;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_qr_en"},      qr_en,        '0);
    check({tag, "_qr_a"},       qr_a,         '0);
    check({tag, "_qr_m"},       qr_m,         '0);
    check({tag, "_qr_m_n"},     qr_m_n,       '0);
    check({tag, "_qr_m_prime"}, qr_m_prime,   '0);
    check({tag, "_cfg_busy"},   cfg_busy,     '0);
    check({tag, "_req_ready"},  rq.req_ready, '0);
    check({tag, "_rsp_valid"},  rq.rsp_valid, '0);
    check({tag, "_rsp_id"},     rq.rsp_id,    '0);
    check({tag, "_rsp_data"},   rq.rsp_data,  '0);
    check({tag, "_rsp_err"},    rq.rsp_err,   '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    cfg_we          = 1'b0;
    rq.req_valid    = '0;
    rq.rsp_ready    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_cfg(input logic [SIZE-1:0] m);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_m       = m;
    cfg_m_n     = {2'b01, m};
    cfg_m_prime = (RADIX+2)'(56'h00_1234_5678_9abc);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Presents one request from idle, checks the grant and the qr_en pulse in the next cycle.
  task automatic start(input int i, input logic [OPW-1:0] a);
    @(negedge clk);
    rq.req_valid = NREQ'(1) << i;
    set_req(i, a);
    #1;
    check("grant_onehot", rq.req_ready, NREQ'(1) << i);
    check("qr_en_low_at_T", qr_en, 1'b0);
    @(negedge clk);
    rq.req_valid = '0;
    #1;
    check("qr_en_at_T+1", qr_en, 1'b1);
    check("qr_a_latched", qr_a, a);
  endtask

  task automatic wait_rsp_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!rq.rsp_valid && n < 400);
  endtask

  task automatic wait_rsps(input int n, output int got);
    got = 0;
    for (int c = 0; c < n * 100 && got < n; c++) begin
      @(negedge clk);
      #1;
      if (rq.rsp_valid && rq.rsp_ready) got++;
    end
  endtask

  logic [SIZE-1:0] m_all;
  int n;
  int got;
  int en_base;
  int seen;

  initial begin
    m_all           = '1;
    rq.req_valid    = '0;
    rq.req_a        = '0;
    rq.rsp_ready    = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    write_cfg(m_all);
    #1;
    check("cfg_qr_m", qr_m, m_all);

    // Single request from requester 2
    start(2, OPW'(5));
    push_exp(2, SIZE'(5), 1'b0);
    wait_rsp_valid(n);
    check("single_rsp_latency", n, 13);
    wait_rsps(1, got);

    // Fairness: all requesters held valid for eight operations
    do_reset();
    write_cfg(m_all);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_req(i, OPW'(10 + i));
    for (int k = 0; k < 8; k++) push_exp(k % NREQ, SIZE'(10 + (k % NREQ)), 1'b0);
    en_base      = en_cnt;
    rq.req_valid = '1;
    wait_rsps(8, got);
    rq.req_valid = '0;
    check("fair_rsp_count", got, 8);
    check("fair_en_count", en_cnt - en_base, 8);

    // Backpressure: response held for 20 cycles while others request
    repeat (2) @(negedge clk);
    rq.rsp_ready = 1'b0;
    rq.req_valid = 4'b0010;
    set_req(1, OPW'(7));
    push_exp(1, SIZE'(7), 1'b0);
    @(negedge clk);
    rq.req_valid = 4'b1001;
    set_req(0, OPW'(20));
    set_req(3, OPW'(30));
    push_exp(3, SIZE'(30), 1'b0);
    push_exp(0, SIZE'(20), 1'b0);
    wait_rsp_valid(n);
    check("bp_rsp_latency", n, 13);
    en_base = en_cnt;
    repeat (20) begin
      @(negedge clk);
      #1;
      check("bp_rsp_valid", rq.rsp_valid, 1'b1);
      check("bp_rsp_id", rq.rsp_id, 2'd1);
      check("bp_rsp_data", rq.rsp_data, SIZE'(7));
      check("bp_rsp_err", rq.rsp_err, 1'b0);
      check("bp_req_ready", rq.req_ready, '0);
      check("bp_qr_en", qr_en, 1'b0);
    end
    check("bp_no_en_pulses", en_cnt - en_base, 0);
    @(negedge clk);
    rq.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_next_grant", rq.req_ready, 4'b1000);
    @(negedge clk);
    rq.req_valid = 4'b0001;
    wait_rsps(2, got);
    rq.req_valid = '0;
    check("bp_follow_count", got, 2);

    // Watchdog expiry with no completion
    hang = 1'b1;
    start(0, OPW'(9));
    push_exp(0, SIZE'(0), 1'b1);
    wait_rsp_valid(n);
    check("timeout_latency", n, TO);
    wait_rsps(1, got);
    hang = 1'b0;

    // Completion in the same cycle the watchdog expires
    lat = TO - 1;
    start(1, OPW'(11));
    push_exp(1, SIZE'(11), 1'b0);
    wait_rsp_valid(n);
    check("race_latency", n, TO);
    wait_rsps(1, got);
    lat = 12;

    // Config guard during WAIT
    start(2, OPW'(3));
    push_exp(2, SIZE'(3), 1'b0);
    repeat (3) @(negedge clk);
    cfg_we = 1'b1;
    cfg_m  = SIZE'(5);
    #1;
    check("cfg_busy_in_wait", cfg_busy, 1'b1);
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    check("cfg_guard_qr_m", qr_m, m_all);
    wait_rsps(1, got);
    write_cfg(SIZE'(100));
    #1;
    check("cfg_idle_qr_m", qr_m, SIZE'(100));
    check("cfg_idle_qr_m_n", qr_m_n, {2'b01, SIZE'(100)});
    check("cfg_idle_qr_m_prime", qr_m_prime, (RADIX+2)'(56'h00_1234_5678_9abc));

    // Config write in the same cycle as a handshake applies to that operation
    @(negedge clk);
    cfg_we       = 1'b1;
    cfg_m        = SIZE'(200);
    rq.req_valid = 4'b1000;
    set_req(3, OPW'(250));
    push_exp(3, SIZE'(50), 1'b0);
    @(negedge clk);
    cfg_we       = 1'b0;
    rq.req_valid = '0;
    #1;
    check("cfg_hs_qr_en", qr_en, 1'b1);
    check("cfg_hs_qr_m", qr_m, SIZE'(200));
    wait_rsps(1, got);
    check("cfg_hs_rsp_count", got, 1);

    // Reset during WAIT aborts silently
    start(1, OPW'(4));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (rq.rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit");
  end

endmodule
